// File: rtl/goertzel_multi_core.sv
// rtl/goertzel_multi_core.sv - N_CH-bin Goertzel recurrence sharing one multiplier over a sample RAM block
module goertzel_multi_core #(
  parameter int D_W    = 16,
  parameter int B_W    = 8,
  parameter int N_CH   = 4,
  parameter int ADDR_W = 9,
  parameter bit SAT    = 1'b1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_CH*D_W-1:0]    coeff,
  input  logic [ADDR_W-1:0]      block_len,
  input  logic [B_W-1:0]         data_n,
  output logic [ADDR_W-1:0]      read_address,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CH_W-1:0]        result_ch,
  output logic [D_W-1:0]         result_t1,
  output logic [D_W-1:0]         result_t2,
  output logic                   ovf,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, ADDR, LOAD, MUL, ACC, RESULT, DONE} state_t;

  localparam int PW = D_W + 2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [D_W-1:0] MAX_V = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0] MIN_V = {1'b1, {(D_W-1){1'b0}}};

  state_t state, next_state;

  logic signed [D_W-1:0]   coeff_reg [N_CH];
  logic signed [D_W-1:0]   t1_reg [N_CH];
  logic signed [D_W-1:0]   t2_reg [N_CH];
  logic [ADDR_W-1:0]       len_reg;
  logic [CH_W-1:0]         ch;
  logic [CH_W-1:0]         ch_inc;
  logic [D_W-1:0]          sample_reg;
  logic signed [PW-1:0]    prod_reg;
  logic signed [PW-1:0]    pre_reg;
  logic signed [PW-1:0]    sum;
  logic signed [2*D_W-1:0] prod_full;
  logic                    sum_ovf;
  logic [D_W-1:0]          acc_val;
  logic                    last_ch;
  logic                    last_sample;

  assign ch_inc      = ch + CH_W'(1);
  assign last_ch     = (ch == LAST_CH);
  assign last_sample = (read_address == len_reg);
  assign prod_full   = coeff_reg[ch] * t1_reg[ch];
  assign sum         = prod_reg + pre_reg;
  // The sum fits D_W bits only when its top three bits agree.
  assign sum_ovf     = !((sum[PW-1:D_W-1] == '0) || (sum[PW-1:D_W-1] == '1));
  assign acc_val     = (sum_ovf && SAT) ? (sum[PW-1] ? MIN_V : MAX_V) : sum[D_W-1:0];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADDR;
      ADDR:    next_state = LOAD;
      LOAD:    next_state = MUL;
      MUL:     next_state = ACC;
      ACC: begin
        if (!last_ch)        next_state = MUL;
        else if (last_sample) next_state = RESULT;
        else                 next_state = ADDR;
      end
      RESULT:  if (result_valid && result_ready && last_ch) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        coeff_reg[c] <= '0;
        t1_reg[c]    <= '0;
        t2_reg[c]    <= '0;
      end
      len_reg      <= '0;
      ch           <= '0;
      sample_reg   <= '0;
      prod_reg     <= '0;
      pre_reg      <= '0;
      read_address <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_t1    <= '0;
      result_t2    <= '0;
      ovf          <= 1'b0;
    end else if (abort) begin
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < N_CH; c++) begin
              coeff_reg[c] <= coeff[c*D_W +: D_W];
              t1_reg[c]    <= '0;
              t2_reg[c]    <= '0;
            end
            len_reg      <= block_len;
            ovf          <= 1'b0;
            ch           <= '0;
            read_address <= '0;
          end
        end
        LOAD: sample_reg <= {{(D_W-B_W){1'b0}}, data_n};
        MUL: begin
          prod_reg <= PW'(prod_full >>> (D_W-2));
          pre_reg  <= $signed({2'b00, sample_reg}) - PW'(t2_reg[ch]);
        end
        ACC: begin
          t1_reg[ch] <= acc_val;
          t2_reg[ch] <= t1_reg[ch];
          if (sum_ovf) ovf <= 1'b1;
          if (!last_ch) begin
            ch <= ch_inc;
          end else begin
            ch <= '0;
            if (!last_sample) read_address <= read_address + ADDR_W'(1);
          end
        end
        RESULT: begin
          // First RESULT cycle loads the beat; afterwards each handshake loads the next one.
          if (!result_valid) begin
            result_valid <= 1'b1;
            result_ch    <= ch;
            result_t1    <= t1_reg[ch];
            result_t2    <= t2_reg[ch];
          end else if (result_ready) begin
            if (last_ch) begin
              result_valid <= 1'b0;
            end else begin
              ch        <= ch_inc;
              result_ch <= ch_inc;
              result_t1 <= t1_reg[ch_inc];
              result_t2 <= t2_reg[ch_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
